// File: rtl/if_instr_mem.sv
// rtl/if_instr_mem.sv - fetch-stage instruction memory with serial byte loader
module if_instr_mem #(
  parameter int NB_ADDR = 32,
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8,
  parameter int DEPTH   = 256,
  localparam int NB_IDX = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_flush,
  input  logic [NB_ADDR-1:0] i_pc,
  input  logic               i_load_valid,
  input  logic [NB_BYTE-1:0] i_load_byte,
  output logic [NB_DATA-1:0] o_instr,
  output logic               o_halt,
  output logic               o_misaligned,
  output logic [NB_IDX:0]    o_load_count,
  output logic               o_load_full
);
  localparam int BPW   = NB_DATA / NB_BYTE;
  localparam int NB_BC = $clog2(BPW);
  localparam logic [NB_IDX:0]    FULL_CNT  = (NB_IDX + 1)'(DEPTH);
  localparam logic [NB_DATA-1:0] HALT_WORD = '1;

  logic [NB_DATA-1:0]         mem [DEPTH];
  logic [NB_BC-1:0]           bc;
  logic [NB_DATA-NB_BYTE-1:0] part;
  logic [NB_DATA-1:0]         word;
  logic [NB_IDX-1:0]          idx;
  logic [NB_IDX:0]            cnt_next;
  logic                       accept;
  logic                       word_done;
  logic                       unused_pc;

  assign idx       = i_pc[NB_IDX+1:2];
  assign accept    = i_load_valid && !o_load_full;
  assign word_done = accept && (bc == NB_BC'(BPW - 1));
  // Earlier bytes sit in the upper bits, so the first byte ends up as the MSB.
  assign word      = {part, i_load_byte};
  assign cnt_next  = o_load_count + (NB_IDX + 1)'(1);
  assign unused_pc = ^i_pc[NB_ADDR-1:NB_IDX+2];

  // No reset on the array: a program survives a core reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset && word_done) begin
      mem[o_load_count[NB_IDX-1:0]] <= word;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_instr      <= '0;
      o_halt       <= 1'b0;
      o_misaligned <= 1'b0;
    end else if (i_flush) begin
      o_instr      <= '0;
      o_halt       <= 1'b0;
      o_misaligned <= 1'b0;
    end else if (i_enable) begin
      o_instr      <= mem[idx];
      o_halt       <= (mem[idx] == HALT_WORD);
      o_misaligned <= |i_pc[1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bc           <= '0;
      part         <= '0;
      o_load_count <= '0;
      o_load_full  <= 1'b0;
    end else if (accept) begin
      part <= word[NB_DATA-NB_BYTE-1:0];
      if (word_done) begin
        bc           <= '0;
        o_load_count <= cnt_next;
        o_load_full  <= (cnt_next == FULL_CNT);
      end else begin
        bc <= bc + NB_BC'(1);
      end
    end
  end
endmodule

// File: tb/tb_if_instr_mem.sv
// tb/tb_if_instr_mem.sv - bench for if_instr_mem: reference model plus directed literal checks
module tb_if_instr_mem;
  localparam int DEPTH = 16;
  localparam int NB_IDX = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic              flush = 1'b0;
  logic [31:0]       pc = '0;
  logic              load_valid = 1'b0;
  logic [7:0]        load_byte = '0;
  logic [31:0]       instr;
  logic              halt;
  logic              misaligned;
  logic [NB_IDX:0]   load_count;
  logic              load_full;

  int tests = 0;
  int fails = 0;

  if_instr_mem #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_flush(flush), .i_pc(pc),
    .i_load_valid(load_valid), .i_load_byte(load_byte), .o_instr(instr), .o_halt(halt),
    .o_misaligned(misaligned), .o_load_count(load_count), .o_load_full(load_full)
  );

  always #5 clk = ~clk;

  // Reference model: counts accepted bytes since reset and keeps a plain word array.
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic [7:0]  m_part [4];
  int          m_bytes = 0;
  logic [31:0] e_instr = '0;
  bit          e_halt = 0, e_mis = 0, e_known = 0, started = 0;

  always @(posedge clk) begin
    if (reset) begin
      e_instr = '0; e_halt = 0; e_mis = 0; e_known = 1; m_bytes = 0; started = 1;
    end else begin
      if (flush) begin
        e_instr = '0; e_halt = 0; e_mis = 0; e_known = 1;
      end else if (enable) begin
        int i;
        i = int'((pc / 4) % DEPTH);
        e_instr = m_mem[i];
        e_known = m_known[i];
        e_halt  = (m_mem[i] == 32'hFFFF_FFFF);
        e_mis   = (pc % 4) != 0;
      end
      if (load_valid && (m_bytes / 4) < DEPTH) begin
        m_part[m_bytes % 4] = load_byte;
        if (m_bytes % 4 == 3) begin
          m_mem[m_bytes / 4]   = {m_part[0], m_part[1], m_part[2], m_part[3]};
          m_known[m_bytes / 4] = 1;
        end
        m_bytes++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model_count", 32'(load_count), 32'(m_bytes / 4));
      chk("model_full", 32'(load_full), 32'((m_bytes / 4) == DEPTH));
      chk("model_mis", 32'(misaligned), 32'(e_mis));
      if (e_known) begin
        chk("model_instr", instr, e_instr);
        chk("model_halt", 32'(halt), 32'(e_halt));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] b);
    load_valid = 1'b1; load_byte = b; tick(); load_valid = 1'b0;
  endtask

  task automatic put_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int k = 0; k < 4; k++) begin
      put_byte(t[31:24]);
      t = t << 8;
    end
  endtask

  task automatic fetch(input logic [31:0] a);
    enable = 1'b1; pc = a; tick(); enable = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
    tick();
    do_reset();
    chk("reset_instr", instr, 32'h0);
    chk("reset_count", 32'(load_count), 32'd0);
    chk("reset_full", 32'(load_full), 32'd0);

    put_word(32'h12345678);
    chk("t1_count", 32'(load_count), 32'd1);
    fetch(32'd0);
    chk("t1_instr", instr, 32'h12345678);

    pc = 32'd4; tick();
    chk("t2_stall", instr, 32'h12345678);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t2_flush", instr, 32'h0);

    put_word(32'hA1B2C3D4);
    put_word(32'hFFFFFFFF);
    fetch(32'd8);
    chk("t3_halt", 32'(halt), 32'd1);
    chk("t3_mis0", 32'(misaligned), 32'd0);
    fetch(32'd9);
    chk("t3_instr9", instr, 32'hFFFFFFFF);
    chk("t3_mis1", 32'(misaligned), 32'd1);
    enable = 1'b1; flush = 1'b1; pc = 32'd8; tick(); enable = 1'b0; flush = 1'b0;
    chk("t3_flush_en_halt", 32'(halt), 32'd0);
    chk("t3_flush_en_mis", 32'(misaligned), 32'd0);

    for (int w = 3; w < DEPTH; w++) begin
      for (int k = 0; k < 4; k++) put_byte(8'(4 * w + k));
    end
    chk("t4_count", 32'(load_count), 32'(DEPTH));
    chk("t4_full", 32'(load_full), 32'd1);
    put_word(32'h99999999);
    chk("t4_count_hold", 32'(load_count), 32'(DEPTH));
    fetch(32'd0);
    chk("t4_mem0", instr, 32'h12345678);
    fetch(32'd60);
    chk("t4_last", instr, 32'h3C3D3E3F);

    fetch(32'(DEPTH * 4 + 4));
    chk("t5_wrap", instr, 32'hA1B2C3D4);
    fetch(32'(DEPTH * 4));
    chk("t5_wrap0", instr, 32'h12345678);

    put_byte(8'hAA); put_byte(8'hBB);
    do_reset();
    chk("t6_count", 32'(load_count), 32'd0);
    chk("t6_full", 32'(load_full), 32'd0);
    fetch(32'd4);
    chk("t6_retained", instr, 32'hA1B2C3D4);
    put_word(32'h11223344);
    fetch(32'd0);
    chk("t6_word0", instr, 32'h11223344);
    put_word(32'h55667788);
    put_word(32'h99AABBCC);
    put_byte(8'hC0); put_byte(8'hFF); put_byte(8'hEE);
    load_valid = 1'b1; load_byte = 8'h01; enable = 1'b1; pc = 32'd12;
    tick();
    load_valid = 1'b0; enable = 1'b0;
    chk("t5_rdw_old", instr, 32'h0C0D0E0F);
    chk("t5_rdw_count", 32'(load_count), 32'd4);
    fetch(32'd12);
    chk("t5_rdw_new", instr, 32'hC0FFEE01);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
